// File: rtl/kernel_control_ap_ctrl_chain_pkg.sv
// Shared types for the ap_ctrl_chain kernel controller.
//   ControlChainInterfaceInput  : host/engine handshake inputs into the controller
//   ControlChainInterfaceOutput : host handshake outputs plus datapath start and endian
//   control_sync_state_ap_ctrl_chain : one-hot controller state
//   decode_state()              : maps a state to its output pattern
package PKG_CONTROL;

    localparam int unsigned WATCHDOG_WIDTH = 32;

    typedef struct packed {
        logic ap_start;
        logic ap_continue;
        logic setup;
        logic done;
    } ControlChainInterfaceInput;

    typedef struct packed {
        logic ap_ready;
        logic ap_done;
        logic ap_idle;
        logic start;
        logic endian;
    } ControlChainInterfaceOutput;

    typedef enum logic [6:0] {
        ST_RESET = 7'b000_0001,
        ST_IDLE  = 7'b000_0010,
        ST_SETUP = 7'b000_0100,
        ST_READY = 7'b000_1000,
        ST_START = 7'b001_0000,
        ST_BUSY  = 7'b010_0000,
        ST_DONE  = 7'b100_0000
    } control_sync_state_ap_ctrl_chain;

    function automatic ControlChainInterfaceOutput decode_state(
        input control_sync_state_ap_ctrl_chain state,
        input logic                            endian
    );
        ControlChainInterfaceOutput out;
        out          = '0;
        out.ap_idle  = (state == ST_IDLE);
        out.ap_ready = (state == ST_READY);
        out.start    = (state == ST_START);
        out.ap_done  = (state == ST_DONE);
        out.endian   = endian;
        return out;
    endfunction

endpackage

// File: rtl/kernel_control_ap_ctrl_chain_counter.sv
// control_counter_saturating: up-counter with synchronous reset and clear.
//   clk    : clock
//   rst    : synchronous active-high reset, forces count to 0
//   clear  : synchronous clear, wins over enable
//   enable : count by one this cycle
//   count  : current value; SATURATE=1 holds at all-ones, SATURATE=0 wraps
module control_counter_saturating #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (!(SATURATE && (&count_q))) begin
                count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/kernel_control_ap_ctrl_chain.sv
// kernel_control_ap_ctrl_chain: ap_ctrl_chain host handshake controller.
// Sequences setup -> start -> busy -> done for the datapath, latches the
// host endian select on each accepted ap_start and reports run statistics.
//   ap_clk              : kernel clock
//   areset              : synchronous active-high reset
//   control_in          : {ap_start, ap_continue, setup, done}
//   endian_in           : host endian select, captured on ap_start accept
//   control_out         : {ap_ready, ap_done, ap_idle, start, endian}, registered
//   busy_cycles         : BUSY cycles of the last/current run (saturating)
//   iteration_count     : runs that reached DONE since reset (wrapping)
//   error_setup_timeout : sticky SETUP watchdog flag, cleared on next accept
//
// state | meaning
// RESET | held in reset, all outputs low
// IDLE  | waiting for ap_start, ap_idle high
// SETUP | waiting for setup engine completion, watchdog running
// READY | one-cycle ap_ready to the host
// START | one-cycle start pulse to the datapath
// BUSY  | datapath running, counting cycles until done
// DONE  | ap_done held until ap_continue
module kernel_control_ap_ctrl_chain
    import PKG_CONTROL::*;
#(
    parameter int unsigned COUNTER_WIDTH        = 32,
    parameter int unsigned SETUP_TIMEOUT_CYCLES = 0
) (
    input  logic                       ap_clk,
    input  logic                       areset,
    input  ControlChainInterfaceInput  control_in,
    input  logic                       endian_in,
    output ControlChainInterfaceOutput control_out,
    output logic [COUNTER_WIDTH-1:0]   busy_cycles,
    output logic [COUNTER_WIDTH-1:0]   iteration_count,
    output logic                       error_setup_timeout
);

    localparam bit WD_EN = (SETUP_TIMEOUT_CYCLES != 0);
    // The watchdog counter reads k during the (k+1)-th SETUP cycle, so the
    // last permitted cycle is the one where it reads limit-1.
    localparam logic [WATCHDOG_WIDTH-1:0] WD_LAST =
        WD_EN ? WATCHDOG_WIDTH'(SETUP_TIMEOUT_CYCLES - 1) : '0;

    control_sync_state_ap_ctrl_chain state_q;
    control_sync_state_ap_ctrl_chain state_d;
    ControlChainInterfaceOutput      ctrl_q;
    ControlChainInterfaceOutput      ctrl_d;
    logic                            error_q;
    logic                            error_d;
    logic                            endian_d;
    logic                            accept;
    logic                            setup_timeout;
    logic [WATCHDOG_WIDTH-1:0]       wd_count;

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        setup_timeout = 1'b0;
        unique case (state_q)
            ST_RESET: state_d = ST_IDLE;
            ST_IDLE: begin
                if (control_in.ap_start) begin
                    state_d = ST_SETUP;
                    accept  = 1'b1;
                end
            end
            ST_SETUP: begin
                // A setup arriving in the final permitted cycle still counts.
                if (control_in.setup) begin
                    state_d = ST_READY;
                end else if (WD_EN && (wd_count == WD_LAST)) begin
                    state_d       = ST_DONE;
                    setup_timeout = 1'b1;
                end
            end
            ST_READY: state_d = ST_START;
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (control_in.done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (control_in.ap_continue) begin
                    if (control_in.ap_start) begin
                        state_d = ST_SETUP;
                        accept  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase

        // The endian output flop doubles as the latch for the host select.
        endian_d = accept ? endian_in : ctrl_q.endian;
        ctrl_d   = decode_state(state_d, endian_d);

        error_d = error_q;
        if (accept) begin
            error_d = 1'b0;
        end else if (setup_timeout) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q <= ST_RESET;
            ctrl_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            error_q <= error_d;
        end
    end

    // busy_cycles clears as START is entered so the host sees 0 during START.
    control_counter_saturating #(
        .WIDTH    (COUNTER_WIDTH),
        .SATURATE (1'b1)
    ) u_busy_counter (
        .clk    (ap_clk),
        .rst    (areset),
        .clear  (state_d == ST_START),
        .enable (state_q == ST_BUSY),
        .count  (busy_cycles)
    );

    control_counter_saturating #(
        .WIDTH    (COUNTER_WIDTH),
        .SATURATE (1'b0)
    ) u_iteration_counter (
        .clk    (ap_clk),
        .rst    (areset),
        .clear  (1'b0),
        .enable ((state_d == ST_DONE) && (state_q != ST_DONE)),
        .count  (iteration_count)
    );

    control_counter_saturating #(
        .WIDTH    (WATCHDOG_WIDTH),
        .SATURATE (1'b1)
    ) u_watchdog_counter (
        .clk    (ap_clk),
        .rst    (areset),
        .clear  (accept),
        .enable (state_q == ST_SETUP),
        .count  (wd_count)
    );

    assign control_out         = ctrl_q;
    assign error_setup_timeout = error_q;

endmodule

// File: tb/tb_kernel_control_ap_ctrl_chain.sv
module tb_kernel_control_ap_ctrl_chain;
    import PKG_CONTROL::*;

    localparam int CW  = 4;
    localparam int TO  = 16;
    localparam int MAXC = (1 << CW) - 1;

    localparam int P_RST   = 0;
    localparam int P_IDLE  = 1;
    localparam int P_SETUP = 2;
    localparam int P_READY = 3;
    localparam int P_START = 4;
    localparam int P_BUSY  = 5;
    localparam int P_DONE  = 6;

    logic                       ap_clk = 1'b0;
    logic                       areset;
    ControlChainInterfaceInput  ci;
    logic                       endian_in;
    ControlChainInterfaceOutput co;
    logic [CW-1:0]              busy_cycles;
    logic [CW-1:0]              iteration_count;
    logic                       error_setup_timeout;

    int vectors     = 0;
    int miscompares = 0;

    kernel_control_ap_ctrl_chain #(
        .COUNTER_WIDTH        (CW),
        .SETUP_TIMEOUT_CYCLES (TO)
    ) dut (
        .ap_clk              (ap_clk),
        .areset              (areset),
        .control_in          (ci),
        .endian_in           (endian_in),
        .control_out         (co),
        .busy_cycles         (busy_cycles),
        .iteration_count     (iteration_count),
        .error_setup_timeout (error_setup_timeout)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic cmp(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: run phase plus plain integer statistics.
    int m_phase   = P_RST;
    int m_busy    = 0;
    int m_iter    = 0;
    int m_elapsed = 0;
    bit m_err     = 0;
    bit m_endian  = 0;
    bit m_valid   = 0;

    always @(posedge ap_clk) begin
        if (areset) begin
            m_phase = P_RST; m_busy = 0; m_iter = 0; m_err = 0; m_endian = 0;
            m_valid = 1;
        end else if (m_valid) begin
            case (m_phase)
                P_RST:   m_phase = P_IDLE;
                P_IDLE:
                    if (ci.ap_start) begin
                        m_phase = P_SETUP; m_endian = endian_in; m_err = 0; m_elapsed = 0;
                    end
                P_SETUP: begin
                    m_elapsed++;
                    if (ci.setup) m_phase = P_READY;
                    else if (m_elapsed == TO) begin
                        m_phase = P_DONE; m_err = 1; m_iter = (m_iter + 1) % (MAXC + 1);
                    end
                end
                P_READY: begin m_phase = P_START; m_busy = 0; end
                P_START: m_phase = P_BUSY;
                P_BUSY: begin
                    m_busy = (m_busy < MAXC) ? m_busy + 1 : MAXC;
                    if (ci.done) begin
                        m_phase = P_DONE; m_iter = (m_iter + 1) % (MAXC + 1);
                    end
                end
                P_DONE:
                    if (ci.ap_continue) begin
                        if (ci.ap_start) begin
                            m_phase = P_SETUP; m_endian = endian_in; m_err = 0; m_elapsed = 0;
                        end else begin
                            m_phase = P_IDLE;
                        end
                    end
                default: m_phase = P_RST;
            endcase
        end
    end

    always @(negedge ap_clk) begin
        if (m_valid) begin
            cmp("ap_idle",  co.ap_idle,  m_phase == P_IDLE);
            cmp("ap_ready", co.ap_ready, m_phase == P_READY);
            cmp("start",    co.start,    m_phase == P_START);
            cmp("ap_done",  co.ap_done,  m_phase == P_DONE);
            cmp("endian",   co.endian,   m_endian);
            cmp("busy_cycles",     busy_cycles,     m_busy);
            cmp("iteration_count", iteration_count, m_iter);
            cmp("error_setup_timeout", error_setup_timeout, m_err);
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #2;
    endtask

    // Called in the first SETUP cycle; returns in the first DONE cycle after n BUSY cycles.
    task automatic finish_run(input int n);
        tick();
        ci.setup = 1'b1;
        tick();
        ci.setup = 1'b0;
        tick();
        tick();
        repeat (n - 1) tick();
        ci.done = 1'b1;
        tick();
        ci.done = 1'b0;
    endtask

    initial begin
        areset = 1'b1; ci = '0; endian_in = 1'b0;
        repeat (2) tick();
        areset = 1'b0;
        cmp("reset_outputs", co, 0);
        cmp("reset_busy", busy_cycles, 0);
        cmp("reset_iter", iteration_count, 0);
        cmp("reset_err", error_setup_timeout, 0);
        tick();
        cmp("idle_after_reset", co.ap_idle, 1);

        // Nominal run with exact handshake latencies.
        tick();
        endian_in = 1'b1; ci.ap_start = 1'b1;
        tick();
        ci.ap_start = 1'b0; endian_in = 1'b0;
        cmp("nom_endian_latched", co.endian, 1);
        repeat (3) tick();
        ci.setup = 1'b1;
        tick();
        ci.setup = 1'b0;
        cmp("nom_ready", co.ap_ready, 1);
        tick();
        cmp("nom_start", co.start, 1);
        cmp("nom_ready_gone", co.ap_ready, 0);
        tick();
        repeat (8) tick();
        ci.done = 1'b1;
        tick();
        ci.done = 1'b0;
        cmp("nom_done", co.ap_done, 1);
        cmp("nom_busy", busy_cycles, 9);
        cmp("nom_iter", iteration_count, 1);
        repeat (3) tick();
        cmp("nom_done_held", co.ap_done, 1);
        ci.ap_continue = 1'b1;
        tick();
        ci.ap_continue = 1'b0;
        cmp("nom_idle", co.ap_idle, 1);
        cmp("nom_done_cleared", co.ap_done, 0);
        cmp("nom_endian_held", co.endian, 1);

        // Back-to-back run.
        areset = 1'b1; tick(); areset = 1'b0; tick();
        endian_in = 1'b1; ci.ap_start = 1'b1;
        tick();
        ci.ap_start = 1'b0;
        finish_run(5);
        cmp("b2b_iter1", iteration_count, 1);
        ci.ap_continue = 1'b1; ci.ap_start = 1'b1; endian_in = 1'b0;
        tick();
        ci.ap_continue = 1'b0; ci.ap_start = 1'b0;
        cmp("b2b_not_idle", co.ap_idle, 0);
        cmp("b2b_endian_relatched", co.endian, 0);
        finish_run(3);
        cmp("b2b_iter2", iteration_count, 2);
        cmp("b2b_busy", busy_cycles, 3);

        // Setup watchdog.
        ci.ap_continue = 1'b1; tick(); ci.ap_continue = 1'b0;
        ci.ap_start = 1'b1; tick(); ci.ap_start = 1'b0;
        repeat (15) tick();
        cmp("wd_not_yet", co.ap_done, 0);
        tick();
        cmp("wd_done", co.ap_done, 1);
        cmp("wd_err", error_setup_timeout, 1);
        cmp("wd_iter", iteration_count, 3);
        ci.ap_continue = 1'b1; ci.ap_start = 1'b1;
        tick();
        ci.ap_continue = 1'b0; ci.ap_start = 1'b0;
        cmp("wd_err_cleared", error_setup_timeout, 0);

        // Reset in the middle of BUSY.
        ci.setup = 1'b1; tick(); ci.setup = 1'b0;
        tick(); tick(); repeat (3) tick();
        areset = 1'b1; tick(); areset = 1'b0;
        cmp("rst_mid_outputs", co, 0);
        cmp("rst_mid_busy", busy_cycles, 0);
        cmp("rst_mid_iter", iteration_count, 0);
        tick();
        cmp("rst_mid_idle", co.ap_idle, 1);

        // Spurious inputs, ap_start held through a whole run.
        ci.done = 1'b1; ci.setup = 1'b1; tick(); ci.done = 1'b0; ci.setup = 1'b0;
        cmp("spur_idle1", co.ap_idle, 1);
        ci.ap_continue = 1'b1; tick(); ci.ap_continue = 1'b0;
        cmp("spur_idle2", co.ap_idle, 1);
        ci.ap_start = 1'b1;
        tick();
        finish_run(6);
        cmp("spur_busy", busy_cycles, 6);
        tick();
        cmp("spur_done_held", co.ap_done, 1);
        ci.ap_start = 1'b0; ci.ap_continue = 1'b1; tick(); ci.ap_continue = 1'b0;

        // BUSY counter saturation.
        ci.ap_start = 1'b1; tick(); ci.ap_start = 1'b0;
        finish_run(20);
        cmp("sat_busy", busy_cycles, 15);
        ci.ap_continue = 1'b1; tick(); ci.ap_continue = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            areset         = ($urandom_range(0, 199) == 0);
            ci.ap_start    = ($urandom_range(0, 3) == 0);
            ci.setup       = ($urandom_range(0, 5) == 0);
            ci.done        = ($urandom_range(0, 9) == 0);
            ci.ap_continue = ($urandom_range(0, 2) == 0);
            endian_in      = 1'($urandom);
            tick();
        end
        areset = 1'b0; ci = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
